// File: rtl/i2c_target_model.sv
// ============================================================================
//  Module   : i2c_target_model
//  Brief    : Behavioural-grade synthesizable I2C target with a small register
//             file. Controller writes a pointer byte and then data bytes, or
//             reads data bytes from the current pointer.
//  Options  : I2C_TARGET_AUTOINC_EN - when defined, the register pointer
//             advances after every data byte and wraps at MemDepth-1.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_target_model #(
    parameter logic [6:0] DeviceAddr = 7'h50,
    parameter int         MemDepth   = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        scl_i,
    input  logic                        sda_i,
    output logic                        sda_oe_o,
    output logic                        busy_o,
    output logic [$clog2(MemDepth)-1:0] ptr_o
);

    localparam int c_PTR_W = $clog2(MemDepth);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_ADDR      = 4'd1,
        S_ADDR_ACK  = 4'd2,
        S_PTR       = 4'd3,
        S_PTR_ACK   = 4'd4,
        S_WDATA     = 4'd5,
        S_WDATA_ACK = 4'd6,
        S_RDATA     = 4'd7,
        S_RDATA_ACK = 4'd8,
        S_IGNORE    = 4'd9
    } state_t;

    // Synchroniser stages and one history flop per line
    logic r_scl_s1, r_scl_s2, r_scl_d;
    logic r_sda_s1, r_sda_s2, r_sda_d;

    state_t               r_state,   w_state_nxt;
    logic [2:0]           r_bit_cnt, w_bit_cnt_nxt;
    logic [7:0]           r_shift,   w_shift_nxt;
    logic [c_PTR_W-1:0]   r_ptr,     w_ptr_nxt;
    logic                 r_sda_oe,  w_sda_oe_nxt;
    logic                 w_mem_we;
    logic [7:0]           r_mem [MemDepth];

    logic                 w_scl_rise, w_scl_fall, w_start, w_stop;
    logic [7:0]           w_byte;
    logic [c_PTR_W-1:0]   w_ptr_inc;

    // Bring SCL/SDA into the clk_i domain; idle-high reset avoids false START/STOP
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_scl_s1 <= 1'b1;
            r_scl_s2 <= 1'b1;
            r_scl_d  <= 1'b1;
            r_sda_s1 <= 1'b1;
            r_sda_s2 <= 1'b1;
            r_sda_d  <= 1'b1;
        end else begin
            r_scl_s1 <= scl_i;
            r_scl_s2 <= r_scl_s1;
            r_scl_d  <= r_scl_s2;
            r_sda_s1 <= sda_i;
            r_sda_s2 <= r_sda_s1;
            r_sda_d  <= r_sda_s2;
        end
    end

    assign w_scl_rise = r_scl_s2 & ~r_scl_d;
    assign w_scl_fall = ~r_scl_s2 & r_scl_d;
    assign w_start    = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
    assign w_stop     = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;

    // Byte as it stands after shifting in the bit on the current SCL rise
    assign w_byte = {r_shift[6:0], r_sda_s2};

`ifdef I2C_TARGET_AUTOINC_EN
    assign w_ptr_inc = r_ptr + c_PTR_W'(1);
`else
    assign w_ptr_inc = r_ptr;
`endif

    // State register and datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'h00;
            r_ptr     <= '0;
            r_sda_oe  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_ptr     <= w_ptr_nxt;
            r_sda_oe  <= w_sda_oe_nxt;
        end
    end

    // Next-state and datapath decode; ACK states use r_sda_oe as their phase:
    // first SCL fall starts the ACK pulse, the following fall ends it
    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_nxt   = r_shift;
        w_ptr_nxt     = r_ptr;
        w_sda_oe_nxt  = r_sda_oe;
        w_mem_we      = 1'b0;

        if (w_start) begin
            w_state_nxt   = S_ADDR;
            w_bit_cnt_nxt = 3'd0;
            w_sda_oe_nxt  = 1'b0;
        end else if (w_stop) begin
            w_state_nxt   = S_IDLE;
            w_bit_cnt_nxt = 3'd0;
            w_sda_oe_nxt  = 1'b0;
        end else begin
            case (r_state)
                S_ADDR: begin
                    if (w_scl_rise) begin
                        w_shift_nxt   = w_byte;
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            w_state_nxt = (w_byte[7:1] == DeviceAddr) ? S_ADDR_ACK : S_IGNORE;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (w_scl_fall) begin
                        if (!r_sda_oe) begin
                            w_sda_oe_nxt = 1'b1;
                        end else if (r_shift[0]) begin
                            // Read: the ACK-ending fall also presents the first data bit
                            w_state_nxt  = S_RDATA;
                            w_shift_nxt  = r_mem[r_ptr];
                            w_sda_oe_nxt = ~r_mem[r_ptr][7];
                        end else begin
                            w_state_nxt  = S_PTR;
                            w_sda_oe_nxt = 1'b0;
                        end
                    end
                end
                S_PTR: begin
                    if (w_scl_rise) begin
                        w_shift_nxt   = w_byte;
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            w_ptr_nxt   = w_byte[c_PTR_W-1:0];
                            w_state_nxt = S_PTR_ACK;
                        end
                    end
                end
                S_WDATA: begin
                    if (w_scl_rise) begin
                        w_shift_nxt   = w_byte;
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            w_mem_we    = 1'b1;
                            w_ptr_nxt   = w_ptr_inc;
                            w_state_nxt = S_WDATA_ACK;
                        end
                    end
                end
                S_PTR_ACK, S_WDATA_ACK: begin
                    if (w_scl_fall) begin
                        if (!r_sda_oe) begin
                            w_sda_oe_nxt = 1'b1;
                        end else begin
                            w_sda_oe_nxt = 1'b0;
                            w_state_nxt  = S_WDATA;
                        end
                    end
                end
                S_RDATA: begin
                    if (w_scl_fall) begin
                        w_sda_oe_nxt = ~r_shift[7];
                    end else if (w_scl_rise) begin
                        w_shift_nxt   = {r_shift[6:0], 1'b0};
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            w_state_nxt = S_RDATA_ACK;
                        end
                    end
                end
                S_RDATA_ACK: begin
                    if (w_scl_fall) begin
                        w_sda_oe_nxt = 1'b0;
                    end else if (w_scl_rise) begin
                        w_ptr_nxt = w_ptr_inc;
                        if (!r_sda_s2) begin
                            w_state_nxt = S_RDATA;
                            w_shift_nxt = r_mem[w_ptr_inc];
                        end else begin
                            w_state_nxt = S_IGNORE;
                        end
                    end
                end
                S_IGNORE: begin
                    w_sda_oe_nxt = 1'b0;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // Register file: cleared on reset, written on the 8th rise of a data byte
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < MemDepth; i++) begin
                r_mem[i] <= 8'h00;
            end
        end else if (w_mem_we) begin
            r_mem[r_ptr] <= w_byte;
        end
    end

    // START/STOP release SDA in the cycle they are seen, ahead of the register
    assign sda_oe_o = r_sda_oe & ~(w_start | w_stop);
    assign busy_o   = (r_state != S_IDLE) && (r_state != S_ADDR) && (r_state != S_IGNORE);
    assign ptr_o    = r_ptr;

endmodule

`default_nettype wire

// File: doc/i2c_target_model.md
I2C_TARGET_MODEL -- requirements
Module: i2c_target_model

Interface
REQ-001 The block SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 Parameter DeviceAddr, default 7'h50, 7-bit target address matched on the bus.
REQ-003 Parameter MemDepth, default 16, register-file depth in bytes; power of two, 2..256.
REQ-004 Port clk_i  input  1  system clock; all state updates on its rising edge.
REQ-005 Port rst_i  input  1  synchronous active-high reset.
REQ-006 Port scl_i  input  1  resolved I2C SCL line, asynchronous to clk_i.
REQ-007 Port sda_i  input  1  resolved I2C SDA line, asynchronous to clk_i.
REQ-008 Port sda_oe_o  output  1  1 = pull SDA low (open-drain); 0 = release.
REQ-009 Port busy_o  output  1  1 while addressed, from address match to STOP, START or NACK exit.
REQ-010 Port ptr_o  output  $clog2(MemDepth)  current register pointer.

Function
REQ-011 scl_i and sda_i SHALL each pass a 2-flop synchroniser plus one history flop; edges and START/STOP are detected from the synchronised values only.
REQ-012 START: synchronised SDA 1->0 while SCL high; STOP: SDA 1->0... corrected: STOP is SDA 0->1 while SCL high; both recognised in any state.
REQ-013 States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
REQ-014 START in any state -> ADDR with the bit counter cleared (repeated START supported); STOP in any state -> IDLE, sda_oe_o released the same cycle.
REQ-015 Bits SHALL be sampled on the detected SCL rising edge, MSB first, 8 bits per byte.
REQ-016 SDA drive changes SHALL occur only on the cycle after a detected SCL falling edge, never while SCL is high.
REQ-017 ADDR: after 8 bits, if bits[7:1]==DeviceAddr -> ADDR_ACK (drive 0 for the 9th clock); otherwise -> IGNORE with SDA released until the next START or STOP.
REQ-018 ADDR_ACK: R/W=0 -> PTR; R/W=1 -> RDATA, loading the shift register with mem[ptr].
REQ-019 PTR: first written byte loads ptr (bits above log2(MemDepth) discarded), ACKed, then -> WDATA.
REQ-020 WDATA: each byte is written to mem[ptr] on its 8th SCL rising edge, ACKed, and ptr increments.
REQ-021 RDATA: the target drives the shifted bit (sda_oe_o = ~bit); after 8 bits it releases SDA and samples the controller ACK on the 9th rising edge; ptr increments.
REQ-022 RDATA_ACK: ACK (0) -> RDATA with mem[ptr] loaded; NACK (1) -> IGNORE.
REQ-023 ptr increment SHALL wrap from MemDepth-1 to 0.
REQ-024 busy_o SHALL be 1 in ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA and RDATA_ACK, and 0 otherwise.
REQ-025 A START or STOP arriving mid-byte SHALL abandon the partial byte with no memory write.

Reset
REQ-026 On rst_i: state IDLE, sda_oe_o 0, busy_o 0, ptr 0, bit counter 0, all memory bytes 8'h00.
REQ-027 Synchroniser and history flops SHALL reset to 1 so that reset release on an idle bus detects no START or STOP.
REQ-028 rst_i asserted mid-transfer SHALL release SDA on the next clk_i edge; bus activity is ignored until the next START.

Configuration
REQ-029 Macro I2C_TARGET_AUTOINC_EN: when defined, ptr increments per REQ-020, REQ-021 and REQ-023.
REQ-030 When I2C_TARGET_AUTOINC_EN is not defined, ptr changes only via PTR-state writes; successive data bytes hit the same location.

Verification
REQ-031 Write 0xA0,0x03,0x11,0x22,STOP -> all four bytes ACKed; mem[3]=0x11, mem[4]=0x22; ptr_o=5; busy_o 0 after STOP.
REQ-032 Write 0xA0,0x03, repeated START, 0xA1, read 2 bytes with ACK then NACK, STOP -> returns 0x11,0x22; SDA released after NACK.
REQ-033 Address 0xA2 -> no ACK (SDA high on 9th clock); busy_o stays 0; memory unchanged.
REQ-034 MemDepth=16: write 0xA0,0x0F,0x55,0x66 -> mem[15]=0x55, mem[0]=0x66, ptr_o=1 (wrap); without the macro, mem[15]=0x66 and ptr_o=15.
REQ-035 rst_i pulsed during the 4th bit of a data byte -> sda_oe_o=0 next cycle, state IDLE, no memory write; the next full transaction succeeds.
REQ-036 STOP injected after 5 bits of a write byte -> no memory write; state IDLE; ptr unchanged.
